// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: controller states,
// partial-product select encoding and the iteration-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of the selected partial product; the sign travels separately.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        PM1  = 2'd1,
        PM2  = 2'd2
    } booth_mag_t;

    typedef struct packed {
        logic       neg;
        booth_mag_t mag;
    } booth_sel_t;

    // Each iteration retires two multiplier bits of the (WIDTH+2)-bit extended operand.
    function automatic int calc_iters(input int width);
        return width / 2 + 1;
    endfunction

    function automatic booth_sel_t booth_decode(input logic [2:0] window);
        booth_sel_t sel;
        sel = '{neg: 1'b0, mag: ZERO};
        unique case (window)
            3'b001, 3'b010: sel = '{neg: 1'b0, mag: PM1};
            3'b011:         sel = '{neg: 1'b0, mag: PM2};
            3'b100:         sel = '{neg: 1'b1, mag: PM2};
            3'b101, 3'b110: sel = '{neg: 1'b1, mag: PM1};
            default:        sel = '{neg: 1'b0, mag: ZERO};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Combinational radix-4 Booth partial-product selector: maps the
// {Q[1],Q[0],Q_1} window and the extended multiplicand to 0/+-M/+-2M.
module booth_r4_pp_sel
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_window,
    input  logic [WIDTH+1:0] i_mcand,
    output logic [WIDTH+2:0] o_pp
);

    localparam int AW = WIDTH + 3;

    booth_sel_t      w_sel;
    logic [AW-1:0]   w_m_ext;
    logic [AW-1:0]   w_mag;

    assign w_sel   = booth_decode(i_window);
    assign w_m_ext = {i_mcand[WIDTH+1], i_mcand};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_mag = '0;
        unique case (w_sel.mag)
            PM1:     w_mag = w_m_ext;
            PM2:     w_mag = {w_m_ext[AW-2:0], 1'b0};
            default: w_mag = '0;
        endcase
        o_pp = w_sel.neg ? -w_mag : w_mag;
    end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier: WIDTH/2+1 add-and-shift iterations,
// signed or unsigned operands, registered product with a one-cycle done pulse.
module booth_mult_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int XW = WIDTH + 2;
    localparam int AW = WIDTH + 3;
    localparam int PW = 2 * WIDTH;
    localparam int N  = calc_iters(WIDTH);
    localparam int CW = $clog2(N + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_acc;
    logic [XW-1:0]   r_q;
    logic            r_q_1;
    logic [WIDTH-1:0] r_m;
    logic            r_signed;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_result;

    logic            w_accept;
    logic            w_last;
    logic [XW-1:0]   w_m_ext;
    logic [AW-1:0]   w_pp;
    logic [AW-1:0]   w_sum;
    logic [AW-1:0]   w_acc_nxt;
    logic [XW-1:0]   w_q_nxt;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CW'(1));
    assign w_m_ext  = {{2{r_signed & r_m[WIDTH-1]}}, r_m};

    booth_r4_pp_sel #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .i_window (r_q[1:0] == 2'b00 ? {2'b00, r_q_1} : {r_q[1:0], r_q_1}),
        .i_mcand  (w_m_ext),
        .o_pp     (w_pp)
    );

    // Add, then arithmetic-shift {acc, Q, Q_1} right by two.
    assign w_sum     = r_acc + w_pp;
    assign w_acc_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_q_nxt   = {w_sum[1:0], r_q[XW-1:2]};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted run leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_q_1    <= 1'b0;
            r_m      <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_q      <= {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
            r_q_1    <= 1'b0;
            r_m      <= multiplicand;
            r_signed <= signed_mode;
            r_cnt    <= CW'(N);
        end else if (r_state == RUN) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_q_1 <= r_q[1];
            r_cnt <= r_cnt - CW'(1);
            // The low 2*WIDTH product bits are exact after the final shift.
            if (w_last) begin
                r_result <= {w_acc_nxt[PW-XW-1:0], w_q_nxt};
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Scoreboard bench for booth_mult_r4 at WIDTH=8 and WIDTH=16: stimulus pushes
// expected products, per-instance monitors pop and compare on every done pulse.
module tb_booth_mult_r4;

    logic        clk;
    logic        rst_n;

    logic        start8, signed8, busy8, done8;
    logic [7:0]  mplier8, mcand8;
    logic [15:0] result8;

    logic        start16, signed16, busy16, done16;
    logic [15:0] mplier16, mcand16;
    logic [31:0] result16;

    logic [15:0] exp8_q[$];
    logic [31:0] exp16_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    booth_mult_r4 #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .signed_mode  (signed8),
        .multiplier   (mplier8),
        .multiplicand (mcand8),
        .busy         (busy8),
        .done         (done8),
        .result       (result8)
    );

    booth_mult_r4 #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start16),
        .signed_mode  (signed16),
        .multiplier   (mplier16),
        .multiplicand (mcand16),
        .busy         (busy16),
        .done         (done16),
        .result       (result16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                check("done8_spurious", {63'd0, done8}, 64'd0);
            end else begin
                check("result8", {48'd0, result8}, {48'd0, exp8_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (exp16_q.size() == 0) begin
                check("done16_spurious", {63'd0, done16}, 64'd0);
            end else begin
                check("result16", {32'd0, result16}, {32'd0, exp16_q.pop_front()});
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where done is seen.
    // lat counts rising edges from start assertion, including the accepting edge.
    task automatic op8(input logic sm, input logic [7:0] q, input logic [7:0] m,
                       input logic [15:0] exp, input logic glitch,
                       output int lat, output int busy_n);
        signed8 = sm; mplier8 = q; mcand8 = m; start8 = 1'b1;
        exp8_q.push_back(exp);
        lat = 0; busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            start8 = glitch && (lat == 2);
            if (glitch && lat == 2) begin
                signed8 = 1'b0; mplier8 = 8'h7F; mcand8 = 8'h7F;
            end
            if (busy8) busy_n++;
            if (done8) break;
        end
    endtask

    task automatic op16(input logic sm, input logic [15:0] q, input logic [15:0] m,
                        input logic [31:0] exp, output int lat);
        signed16 = sm; mplier16 = q; mcand16 = m; start16 = 1'b1;
        exp16_q.push_back(exp);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            start16 = 1'b0;
            if (done16) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n;
        logic [15:0] rq, rm;
        logic        rs;
        logic [31:0] rexp;

        rst_n = 1'b0;
        start8 = 0; signed8 = 0; mplier8 = '0; mcand8 = '0;
        start16 = 0; signed16 = 0; mplier16 = '0; mcand16 = '0;

        #12;
        check("rst_busy8",    {63'd0, busy8},    64'd0);
        check("rst_done8",    {63'd0, done8},    64'd0);
        check("rst_result8",  {48'd0, result8},  64'd0);
        check("rst_result16", {32'd0, result16}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // 3 x 2 signed: latency and busy duration
        op8(1'b1, 8'h03, 8'h02, 16'h0006, 1'b0, lat, busy_n);
        check("lat_3x2",  lat,    64'd6);
        check("busy_3x2", busy_n, 64'd5);
        @(negedge clk);
        check("done_low_after", {63'd0, done8}, 64'd0);
        check("result_held",    {48'd0, result8}, 64'h0006);

        op8(1'b1, 8'h85, 8'hFC, 16'h01EC, 1'b0, lat, busy_n);
        @(negedge clk);
        op8(1'b1, 8'h0B, 8'hFF, 16'hFFF5, 1'b0, lat, busy_n);
        @(negedge clk);
        op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, lat, busy_n);
        @(negedge clk);
        op8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, lat, busy_n);
        @(negedge clk);
        op8(1'b0, 8'h80, 8'h02, 16'h0100, 1'b0, lat, busy_n);
        @(negedge clk);
        op8(1'b1, 8'h80, 8'h02, 16'hFF00, 1'b0, lat, busy_n);
        @(negedge clk);
        op8(1'b0, 8'hFF, 8'h01, 16'h00FF, 1'b0, lat, busy_n);
        @(negedge clk);
        op8(1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b0, lat, busy_n);
        @(negedge clk);

        // start during RUN must be ignored
        op8(1'b1, 8'h07, 8'h09, 16'h003F, 1'b1, lat, busy_n);
        check("lat_glitch", lat, 64'd6);
        repeat (8) @(negedge clk);

        // back-to-back: second start issued while in DONE
        op8(1'b0, 8'h10, 8'h10, 16'h0100, 1'b0, lat, busy_n);
        op8(1'b1, 8'h7F, 8'h81, 16'hC0FF, 1'b0, lat, busy_n);
        check("lat_b2b", lat, 64'd6);
        @(negedge clk);

        // reset in RUN cycle 3 aborts the operation
        signed8 = 1'b0; mplier8 = 8'd200; mcand8 = 8'd100; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy8",   {63'd0, busy8},   64'd0);
        check("abort_done8",   {63'd0, done8},   64'd0);
        check("abort_result8", {48'd0, result8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        op8(1'b0, 8'h05, 8'h07, 16'h0023, 1'b0, lat, busy_n);
        check("lat_after_abort", lat, 64'd6);
        @(negedge clk);

        // WIDTH=16
        op16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, lat);
        check("lat16", lat, 64'd10);
        @(negedge clk);
        op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, lat);
        @(negedge clk);
        op16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, lat);
        @(negedge clk);
        op16(1'b1, 16'h8000, 16'h8000, 32'h40000000, lat);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rq = 16'($urandom);
            rm = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (rs) rexp = $signed(rq) * $signed(rm);
            else    rexp = rq * rm;
            op16(rs, rq, rm, rexp, lat);
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("drained8",  exp8_q.size(),  64'd0);
        check("drained16", exp16_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
